ui_frame_sequencer: RTL

//  Sits directly downstream of the arrow-drawing datapath and upstream of vga_adapter.
//  On a start pulse it optionally sweeps the 160x120 screen to a background colour.
//  It then enables the arrow drawer and forwards its x/y stream to the adapter in the latched colour.

---
 rtl/ui_frame_sequencer.sv | 126 ++++++++++++
 1 files changed

// File: rtl/ui_frame_sequencer.sv
// ui_frame_sequencer: sits between the arrow-drawing datapath and vga_adapter.
// A start pulse optionally clears the screen to BG_COLOUR, then hands the
// adapter over to the arrow drawer until it reports done or times out.
// Build option: define UI_FRAME_CLEAR_EN to include the background clear sweep.
// Without it, an accepted start goes straight to DRAW.
module ui_frame_sequencer #(
  parameter int          H_RES          = 160,
  parameter int          V_RES          = 120,
  parameter logic [2:0]  BG_COLOUR      = 3'b000,
  parameter int          TIMEOUT_CYCLES = 60000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [2:0] colour_in,
  input  logic [7:0] arrow_x,
  input  logic [6:0] arrow_y,
  input  logic       arrow_done,
  output logic       arrow_enable,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot,
  output logic       busy,
  output logic       frame_done,
  output logic       timeout_err
);

`ifdef UI_FRAME_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  // CLEAR is unreachable in this build and is pruned by synthesis
  localparam bit CLEAR_EN = 1'b0;
`endif

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_DRAW  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [7:0]  X_LAST   = 8'(H_RES - 1);
  localparam logic [6:0]  Y_LAST   = 7'(V_RES - 1);
  localparam logic [25:0] TMO_LAST = 26'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state;
  logic [2:0]  colour_q;
  logic [25:0] tmo_cnt;

  // Frame FSM; every output is a register loaded on the transition into the
  // cycle where it must be visible. The clear sweep reuses vga_x/vga_y as
  // its raster counters.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      colour_q     <= 3'b000;
      tmo_cnt      <= '0;
      arrow_enable <= 1'b0;
      vga_x        <= '0;
      vga_y        <= '0;
      vga_colour   <= 3'b000;
      vga_plot     <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        S_IDLE: begin
          vga_plot <= 1'b0;
          if (start) begin
            colour_q    <= colour_in;
            timeout_err <= 1'b0;
            busy        <= 1'b1;
            if (CLEAR_EN) begin
              state      <= S_CLEAR;
              vga_x      <= '0;
              vga_y      <= '0;
              vga_colour <= BG_COLOUR;
              vga_plot   <= 1'b1;
            end else begin
              state        <= S_DRAW;
              arrow_enable <= 1'b1;
              tmo_cnt      <= '0;
            end
          end
        end
        S_CLEAR: begin
          if (vga_x == X_LAST && vga_y == Y_LAST) begin
            // last BG pixel shown; drawer output is not valid until next cycle
            state        <= S_DRAW;
            arrow_enable <= 1'b1;
            vga_plot     <= 1'b0;
            tmo_cnt      <= '0;
          end else if (vga_x == X_LAST) begin
            vga_x <= '0;
            vga_y <= vga_y + 7'd1;
          end else begin
            vga_x <= vga_x + 8'd1;
          end
        end
        S_DRAW: begin
          if (arrow_done || tmo_cnt == TMO_LAST) begin
            // arrow_done has priority, so a same-cycle timeout is not an error
            state        <= S_DONE;
            arrow_enable <= 1'b0;
            vga_plot     <= 1'b0;
            frame_done   <= 1'b1;
            if (!arrow_done) timeout_err <= 1'b1;
          end else begin
            vga_x      <= arrow_x;
            vga_y      <= arrow_y;
            vga_colour <= colour_q;
            vga_plot   <= 1'b1;
            tmo_cnt    <= tmo_cnt + 26'd1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
